// File: rtl/seg7_decode_monitor.sv
// Recovers the digit shown on an active-low 7-segment bus, filters transient patterns and
// checks that accepted digits follow 0-9 counting order, counting invalid and sequence errors.
module seg7_decode_monitor #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           seg_in,
   output logic [3:0]           digit,
   output logic                 digit_valid,
   output logic                 blank,
   output logic                 invalid,
   output logic                 seq_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);
   localparam logic [6:0] SegBlank  = 7'b1111111;

   typedef enum logic [1:0] {ClsDigit, ClsBlank, ClsInvalid} seg_cls_e;

   typedef struct packed {
      seg_cls_e   cls;
      logic [3:0] val;
   } seg_dec_t;

   function automatic seg_dec_t decode(input logic [6:0] seg);
      seg_dec_t d;
      d.cls = ClsDigit;
      d.val = 4'd0;
      case (seg)
         7'b0000001: d.val = 4'd0;
         7'b1001111: d.val = 4'd1;
         7'b0010010: d.val = 4'd2;
         7'b0000110: d.val = 4'd3;
         7'b1001100: d.val = 4'd4;
         7'b0100100: d.val = 4'd5;
         7'b0100000: d.val = 4'd6;
         7'b0001111: d.val = 4'd7;
         7'b0000000: d.val = 4'd8;
         7'b0000100: d.val = 4'd9;
         SegBlank:   d.cls = ClsBlank;
         default:    d.cls = ClsInvalid;
      endcase
      return d;
   endfunction

   // Input sampling and stability filter
   logic [6:0] seg_q;
   logic       seg_vld_q;
   logic [6:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;

   // Acceptance bookkeeping
   logic [6:0] acc_q, acc_d;
   logic       none_q, none_d;
   logic       accept;
   seg_dec_t   dec;

   // Registered outputs
   logic [3:0]           digit_q, digit_d;
   logic                 digit_valid_q, digit_valid_d;
   logic                 blank_q, blank_d;
   logic                 invalid_q, invalid_d;
   logic                 seq_err_q, seq_err_d;
   logic                 locked_q, locked_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic [3:0]           next_digit;

   // seg_q holds a real sample only from the first edge after reset release onwards, so the
   // cleared value is never counted as a pattern.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (seg_vld_q) begin
         if (cnt_q == 8'd0 || seg_q != cand_q) begin
            cand_d = seg_q;
            cnt_d  = 8'd1;
         end else if (cnt_q < StableCnt) begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   assign accept = seg_vld_q && (cnt_d == StableCnt) && (cnt_q != StableCnt) &&
                   (none_q || cand_d != acc_q);
   assign dec        = decode(cand_d);
   assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

   always_comb begin
      acc_d         = acc_q;
      none_d        = none_q;
      digit_d       = digit_q;
      digit_valid_d = 1'b0;
      blank_d       = blank_q;
      invalid_d     = invalid_q;
      seq_err_d     = 1'b0;
      locked_d      = locked_q;
      err_d         = err_q;
      if (accept) begin
         acc_d  = cand_d;
         none_d = 1'b0;
         unique case (dec.cls)
            ClsDigit: begin
               digit_d       = dec.val;
               digit_valid_d = 1'b1;
               blank_d       = 1'b0;
               invalid_d     = 1'b0;
               locked_d      = 1'b1;
               // digit_q is the previous valid digit whenever locked_q is set
               if (locked_q && dec.val != next_digit) begin
                  seq_err_d = 1'b1;
                  if (err_q != '1) err_d = err_q + 1'b1;
               end
            end
            ClsBlank: begin
               blank_d   = 1'b1;
               invalid_d = 1'b0;
            end
            ClsInvalid: begin
               invalid_d = 1'b1;
               blank_d   = 1'b0;
               if (err_q != '1) err_d = err_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q         <= 7'd0;
         seg_vld_q     <= 1'b0;
         cand_q        <= 7'd0;
         cnt_q         <= 8'd0;
         acc_q         <= 7'd0;
         none_q        <= 1'b1;
         digit_q       <= 4'd0;
         digit_valid_q <= 1'b0;
         blank_q       <= 1'b0;
         invalid_q     <= 1'b0;
         seq_err_q     <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= '0;
      end else begin
         seg_q         <= seg_in;
         seg_vld_q     <= 1'b1;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         none_q        <= none_d;
         digit_q       <= digit_d;
         digit_valid_q <= digit_valid_d;
         blank_q       <= blank_d;
         invalid_q     <= invalid_d;
         seq_err_q     <= seq_err_d;
         locked_q      <= locked_d;
         err_q         <= err_d;
      end
   end

   assign digit       = digit_q;
   assign digit_valid = digit_valid_q;
   assign blank       = blank_q;
   assign invalid     = invalid_q;
   assign seq_err     = seq_err_q;
   assign locked      = locked_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Scoreboard bench for seg7_decode_monitor: directed patterns push expected output events,
// a monitor pops and compares them (value and cycle) whenever the DUT outputs change or pulse.
module tb_seg7_decode_monitor;

   localparam int unsigned S = 4;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] I1 = 7'b1111110;
   localparam logic [6:0] I2 = 7'b1111101;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg_in = 7'b1111111;
   logic [3:0] digit;
   logic       digit_valid, blank, invalid, seq_err, locked;
   logic [1:0] err_count;

   seg7_decode_monitor #(
      .STABLE_CYCLES(S),
      .ERR_CNT_W    (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_in     (seg_in),
      .digit      (digit),
      .digit_valid(digit_valid),
      .blank      (blank),
      .invalid    (invalid),
      .seq_err    (seq_err),
      .locked     (locked),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] digit;
      logic       dv;
      logic       blank;
      logic       inv;
      logic       serr;
      logic       locked;
      logic [1:0] err;
   } snap_t;

   logic [6:0] dig [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   int    cyc = 0;
   int    ncheck = 0;
   int    nerr = 0;
   int    rel_cyc = 0;
   bit    mon_en = 1'b0;
   snap_t cur, prev;
   snap_t exp_q[$];
   int    exp_cyc[$];
   string exp_nm[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic snap_t mk(input int d, input bit dv, input bit b, input bit i,
                                input bit s, input bit l, input int e);
      return {4'(d), dv, b, i, s, l, 2'(e)};
   endfunction

   function automatic logic [8:0] lev(input snap_t s);
      return {s.digit, s.blank, s.inv, s.locked, s.err};
   endfunction

   // Monitor: an output event is any pulse or any change in the level outputs.
   always @(posedge clk) begin
      #1;
      cur = {digit, digit_valid, blank, invalid, seq_err, locked, err_count};
      if (mon_en && (cur.dv || cur.serr || lev(cur) != lev(prev))) begin
         ncheck++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_event got=%03h at cycle %0d required no event", cur, cyc);
         end else begin
            snap_t e;
            int    ec;
            string nm;
            e  = exp_q.pop_front();
            ec = exp_cyc.pop_front();
            nm = exp_nm.pop_front();
            if (cur !== e || cyc != ec) begin
               nerr++;
               $display("FAIL %s got=%03h at cycle %0d required=%03h at cycle %0d",
                        nm, cur, cyc, e, ec);
            end
         end
      end
      prev = cur;
   end

   task automatic check_zero(input string nm);
      snap_t s;
      s = {digit, digit_valid, blank, invalid, seq_err, locked, err_count};
      ncheck++;
      if (s !== '0) begin
         nerr++;
         $display("FAIL %s got=%03h required=000", nm, s);
      end
   endtask

   // Called at a negedge; returns at the negedge one cycle after release.
   task automatic do_reset(input int n, input logic [6:0] rel, input bit rnd);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (rnd) seg_in = 7'($urandom);
         @(posedge clk);
         #1;
         check_zero("in_reset");
         @(negedge clk);
      end
      rst_n   = 1'b1;
      seg_in  = rel;
      rel_cyc = cyc;
      @(posedge clk);
      #1;
      check_zero("after_release");
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   // Drive a pattern for hold cycles; base is the cycle the pattern first appeared (-1: now).
   task automatic apply(input logic [6:0] pat, input int hold, input int base, input bit ev,
                        input snap_t e, input string nm);
      seg_in = pat;
      if (ev) begin
         exp_q.push_back(e);
         exp_cyc.push_back(((base < 0) ? cyc : base) + int'(S) + 1);
         exp_nm.push_back(nm);
      end
      repeat (hold) @(negedge clk);
   endtask

   initial begin
      // Reset with random input, then count 0..9
      do_reset(3, dig[0], 1'b1);
      for (int i = 0; i < 10; i++)
         apply(dig[i], 8, (i == 0) ? rel_cyc : -1, 1'b1, mk(i, 1, 0, 0, 0, 1, 0), "count_up");

      // 9 -> blank -> 0 wraps without a sequence error
      apply(dig[9], 8, -1, 1'b0, '0, "");
      apply(BL, 6, -1, 1'b1, mk(9, 0, 1, 0, 0, 1, 0), "blank");
      apply(dig[0], 8, -1, 1'b1, mk(0, 1, 0, 0, 0, 1, 0), "wrap_zero");

      // Short glitch is ignored; 3 -> 7 is a sequence error
      do_reset(2, dig[3], 1'b1);
      apply(dig[3], 10, rel_cyc, 1'b1, mk(3, 1, 0, 0, 0, 1, 0), "glitch_first3");
      apply(dig[7], 3, -1, 1'b0, '0, "");
      apply(dig[3], 10, -1, 1'b0, '0, "");
      apply(dig[7], 4, -1, 1'b1, mk(7, 1, 0, 0, 1, 1, 1), "seq_err7");
      apply(BL, 8, -1, 1'b1, mk(7, 0, 1, 0, 0, 1, 1), "blank_after7");

      // Invalid pattern keeps the digit and counts an error
      do_reset(2, dig[5], 1'b1);
      apply(dig[5], 8, rel_cyc, 1'b1, mk(5, 1, 0, 0, 0, 1, 0), "digit5");
      apply(I1, 4, -1, 1'b1, mk(5, 0, 0, 1, 0, 1, 1), "invalid");
      apply(dig[6], 8, -1, 1'b1, mk(6, 1, 0, 0, 0, 1, 1), "digit6");

      // Error counter saturates at 3
      do_reset(2, I1, 1'b1);
      apply(I1, 6, rel_cyc, 1'b1, mk(0, 0, 0, 1, 0, 0, 1), "sat_err1");
      apply(I2, 6, -1, 1'b1, mk(0, 0, 0, 1, 0, 0, 2), "sat_err2");
      apply(I1, 6, -1, 1'b1, mk(0, 0, 0, 1, 0, 0, 3), "sat_err3");
      apply(I2, 6, -1, 1'b0, '0, "");
      apply(I1, 6, -1, 1'b0, '0, "");
      ncheck++;
      if (err_count !== 2'd3) begin
         nerr++;
         $display("FAIL err_saturate got=%0d required=3", err_count);
      end

      // Reset in the middle of a stable window restarts the full window
      apply(dig[2], 2, -1, 1'b0, '0, "");
      do_reset(1, dig[2], 1'b0);
      apply(dig[2], 8, rel_cyc, 1'b1, mk(2, 1, 0, 0, 0, 1, 0), "mid_reset_accept");

      repeat (10) @(negedge clk);
      ncheck++;
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
      $finish;
   end

endmodule
